icache_controller: RTL and testbench

- Direct-mapped instruction cache controller between the fetch stage and the off-chip instruction memory.
- Looks up the 32-bit instructions the fetch stage requests.
- On a miss, fetches the 64-bit line from off-chip memory through its read_enable/data_ready handshake, refills the line and forwards the requested half.
- Keeps saturating hit/miss statistics.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_line_array.sv | 41 ++++
 rtl/icache_controller.sv | 116 +++++++++++
 tb/tb_icache_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Address field layout, FSM state codes and line helpers.
package icache_pkg;

  localparam int OFFSET_W    = 1;
  localparam int INDEX_W     = 3;
  localparam int TAG_W       = 3;
  localparam int NUM_LINES   = 1 << INDEX_W;
  localparam int ADDR_W      = OFFSET_W + INDEX_W + TAG_W;
  localparam int MEM_ADDR_W  = INDEX_W + TAG_W;
  localparam int IDX_LSB     = OFFSET_W;
  localparam int TAG_LSB     = OFFSET_W + INDEX_W;
  localparam int LINE_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int MEM_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } state_e;

  function automatic logic [INSTR_W-1:0] sel_half(
    input logic [LINE_W-1:0] line,
    input logic              half
  );
    return half ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache.
// Synchronous write, asynchronous read; only valid bits reset.
module icache_line_array
  import icache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                i_we,
  input  logic [INDEX_W-1:0]  i_widx,
  input  logic [TAG_W-1:0]    i_wtag,
  input  logic [LINE_W-1:0]   i_wdata,
  input  logic [INDEX_W-1:0]  i_ridx,
  output logic                o_valid,
  output logic [TAG_W-1:0]    o_tag,
  output logic [LINE_W-1:0]   o_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: lookup, line refill
// from off-chip memory, and saturating hit/miss statistics.
module icache_controller
  import icache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_W-1:0]     cpu_addr,
  output logic                  cpu_ready,
  output logic [INSTR_W-1:0]    cpu_instr,
  output logic                  cpu_busy,
  output logic                  mem_read_enable,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic                  mem_data_ready,
  input  logic [LINE_W-1:0]     mem_data_bus,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  state_e                r_state;
  state_e                w_next;
  logic                  r_half;
  logic                  r_ready;
  logic [INSTR_W-1:0]    r_instr;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]      r_hits;
  logic [CNT_W-1:0]      r_misses;

  logic                  w_valid;
  logic [TAG_W-1:0]      w_tag;
  logic [LINE_W-1:0]     w_data;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fill;

  icache_line_array u_lines (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_fill),
    .i_widx  (r_mem_addr[INDEX_W-1:0]),
    .i_wtag  (r_mem_addr[MEM_ADDR_W-1:INDEX_W]),
    .i_wdata (mem_data_bus),
    .i_ridx  (cpu_addr[IDX_LSB +: INDEX_W]),
    .o_valid (w_valid),
    .o_tag   (w_tag),
    .o_data  (w_data)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    w_miss = 1'b0;
    w_fill = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (w_valid && (w_tag == cpu_addr[TAG_LSB +: TAG_W])) begin
            w_hit = 1'b1;
          end else begin
            w_miss = 1'b1;
            w_next = MISS_REQ;
          end
        end
      end
      MISS_REQ: w_next = MISS_WAIT;
      MISS_WAIT: begin
        if (mem_data_ready) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The refilled half is forwarded straight from the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_half     <= 1'b0;
      r_ready    <= 1'b0;
      r_instr    <= '0;
      r_mem_addr <= '0;
      r_hits     <= '0;
      r_misses   <= '0;
    end else begin
      r_ready <= w_hit | w_fill;
      if (w_hit) begin
        r_instr <= sel_half(w_data, cpu_addr[0]);
        if (r_hits != '1) r_hits <= r_hits + CNT_W'(1);
      end
      if (w_miss) begin
        r_half     <= cpu_addr[0];
        r_mem_addr <= cpu_addr[ADDR_W-1:OFFSET_W];
        if (r_misses != '1) r_misses <= r_misses + CNT_W'(1);
      end
      if (w_fill) r_instr <= sel_half(mem_data_bus, r_half);
    end
  end

  assign cpu_ready       = r_ready;
  assign cpu_instr       = r_instr;
  assign cpu_busy        = (r_state != IDLE);
  assign mem_read_enable = (r_state == MISS_REQ);
  assign mem_address     = r_mem_addr;
  assign hit_count       = r_hits;
  assign miss_count      = r_misses;

endmodule

// File: tb/tb_icache_controller.sv
// Directed and random fetch sequences for icache_controller,
// with the bench acting as the fixed-latency off-chip memory.
module tb_icache_controller;
  import icache_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [6:0]  cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_instr;
  logic        cpu_busy;
  logic        mem_read_enable;
  logic [5:0]  mem_address;
  logic        mem_data_ready;
  logic [63:0] mem_data_bus;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  icache_controller #(.CNT_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_req         (cpu_req),
    .cpu_addr        (cpu_addr),
    .cpu_ready       (cpu_ready),
    .cpu_instr       (cpu_instr),
    .cpu_busy        (cpu_busy),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_data_ready  (mem_data_ready),
    .mem_data_bus    (mem_data_bus),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] mem [64];
  bit          m_valid [8];
  logic [2:0]  m_tag [8];
  int          m_hits;
  int          m_miss;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_instr(input logic [6:0] a);
    logic [63:0] l;
    l = mem[a[6:1]];
    return a[0] ? l[63:32] : l[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, cpu_ready, 0);
    check({tag, "_instr"}, cpu_instr, 0);
    check({tag, "_busy"}, cpu_busy, 0);
    check({tag, "_rden"}, mem_read_enable, 0);
    check({tag, "_maddr"}, mem_address, 0);
    check({tag, "_hits"}, hit_count, 0);
    check({tag, "_miss"}, miss_count, 0);
  endtask

  // One request presented in the current (IDLE) cycle, run to completion.
  task automatic fetch(input logic [6:0] a, input bit hold);
    logic [2:0] idx;
    bit         hit;
    idx = a[3:1];
    hit = m_valid[idx] && (m_tag[idx] == a[6:4]);
    cpu_req  = 1'b1;
    cpu_addr = a;
    tick();
    if (!hold) cpu_req = 1'b0;
    if (hit) begin
      if (m_hits < 65535) m_hits++;
      check("hit_ready", cpu_ready, 1);
      check("hit_instr", cpu_instr, exp_instr(a));
      check("hit_rden", mem_read_enable, 0);
      check("hit_busy", cpu_busy, 0);
      check("hit_count", hit_count, m_hits);
    end else begin
      if (m_miss < 65535) m_miss++;
      check("miss_rden", mem_read_enable, 1);
      check("miss_addr", mem_address, a[6:1]);
      check("miss_busy", cpu_busy, 1);
      check("miss_ready", cpu_ready, 0);
      check("miss_count", miss_count, m_miss);
      for (int c = 2; c <= MEM_LATENCY + 1; c++) begin
        tick();
        check("wait_rden", mem_read_enable, 0);
        check("wait_busy", cpu_busy, 1);
        check("wait_addr", mem_address, a[6:1]);
        check("wait_ready", cpu_ready, 0);
      end
      mem_data_ready = 1'b1;
      mem_data_bus   = mem[a[6:1]];
      tick();
      mem_data_ready = 1'b0;
      mem_data_bus   = {$urandom, $urandom};
      check("fill_ready", cpu_ready, 1);
      check("fill_instr", cpu_instr, exp_instr(a));
      check("fill_busy", cpu_busy, 0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[6:4];
    end
  endtask

  initial begin
    logic [6:0] a;
    logic [2:0] ix;

    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'hBBBBBBBB_AAAAAAAA;

    reset          = 1'b1;
    cpu_req        = 1'b0;
    cpu_addr       = '0;
    mem_data_ready = 1'b0;
    mem_data_bus   = '0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check_all_zero("rst");

    fetch(7'd0, 1'b0);
    check("cold_instr", cpu_instr, 32'hAAAAAAAA);
    check("cold_miss", miss_count, 1);

    fetch(7'd1, 1'b0);
    check("hit1_instr", cpu_instr, 32'hBBBBBBBB);
    check("hit1_count", hit_count, 1);

    fetch(7'd16, 1'b0);
    fetch(7'd0, 1'b0);
    check("conflict_miss", miss_count, 3);

    // Held request during a miss is serviced again once back in IDLE.
    fetch(7'd2, 1'b1);
    fetch(7'd2, 1'b0);

    for (int n = 0; n < 60; n++) begin
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) a[6:5] = 2'b00;
      fetch(a, 1'b0);
    end

    mem_data_ready = 1'b1;
    mem_data_bus   = {$urandom, $urandom};
    tick();
    mem_data_ready = 1'b0;
    check("stray_ready", cpu_ready, 0);
    check("stray_busy", cpu_busy, 0);
    check("stray_hits", hit_count, m_hits);
    check("stray_miss", miss_count, m_miss);

    ix = 3'd2;
    a  = {(m_valid[ix] ? 3'(m_tag[ix] + 3'd1) : 3'd0), ix, 1'b1};
    cpu_req  = 1'b1;
    cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    check("mid_rden", mem_read_enable, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_all_zero("midrst");
    fetch(a, 1'b0);
    check("rerun_miss", miss_count, 1);
    fetch(7'd0, 1'b0);
    check("rerun_miss0", miss_count, 2);

    cpu_req  = 1'b1;
    cpu_addr = 7'd0;
    for (int n = 0; n < 65540; n++) begin
      tick();
      if (m_hits < 65535) m_hits++;
    end
    cpu_req = 1'b0;
    check("sat_ready", cpu_ready, 1);
    check("sat_model", hit_count, m_hits);
    check("sat_hits", hit_count, 16'hFFFF);
    tick();
    check("sat_idle", cpu_ready, 0);
    check("sat_hold", hit_count, 16'hFFFF);
    fetch(7'd1, 1'b0);
    check("sat_after", hit_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
